adc_spi_capture: RTL and testbench

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

---
 rtl/adc_spi_capture.sv | 137 +++++++++++++
 tb/tb_adc_spi_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: drives a dual-channel serial ADC and captures one 12-bit
// sample per channel per frame.
//
// Frame: CS_N low, 16 SCLK rising edges (SCLK idles high). Data is shifted in
// MSB first on each SCLK rise. The first 4 bits are leading zeros and are not
// kept. The last 12 bits become POT/REF. A quiet period of QUIET_CYC cycles
// follows each frame.
//
// Parameters
//   CLK_DIV   clk cycles per SCLK half-period (2..255)
//   QUIET_CYC minimum clk cycles in QUIET after a frame (1..255)
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   Ena_ADC  level-sensitive conversion enable
//   SDATA0   serial data, channel 0 (potentiometer)
//   SDATA1   serial data, channel 1 (reference)
//   CS_N     ADC chip select, active low, registered
//   SCLK     ADC serial clock, registered, idles high
//   POT      last completed channel-0 sample, zero-extended to 18 bits
//   REF      last completed channel-1 sample, zero-extended to 18 bits
//   valid    one-cycle pulse when POT/REF update
//   busy     high in CONV and QUIET
module adc_spi_capture #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned QUIET_CYC = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Ena_ADC,
   input  logic        SDATA0,
   input  logic        SDATA1,
   output logic        CS_N,
   output logic        SCLK,
   output logic [17:0] POT,
   output logic [17:0] REF,
   output logic        valid,
   output logic        busy
);

   localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
   localparam logic [7:0] QuietLast = 8'(QUIET_CYC - 1);

   typedef enum logic [1:0] {StIdle, StConv, StQuiet} state_e;

   state_e      state_q;
   logic [7:0]  div_q;
   logic [4:0]  bit_q;
   logic [7:0]  quiet_q;
   logic [11:0] sh0_q;
   logic [11:0] sh1_q;
   logic        cs_n_q;
   logic        sclk_q;
   logic [17:0] pot_q;
   logic [17:0] ref_q;
   logic        valid_q;
   logic        busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         quiet_q <= '0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         pot_q   <= '0;
         ref_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (Ena_ADC) begin
                  state_q <= StConv;
                  cs_n_q  <= 1'b0;
                  sclk_q  <= 1'b1;
                  div_q   <= '0;
                  bit_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StConv: begin
               if (div_q == DivLast) begin
                  div_q  <= '0;
                  sclk_q <= ~sclk_q;
                  // SCLK currently low, so this toggle is a rising edge: sample.
                  if (!sclk_q) begin
                     // 16 bits shift through 12-bit registers; the leading
                     // zeros fall off the top.
                     sh0_q <= {sh0_q[10:0], SDATA0};
                     sh1_q <= {sh1_q[10:0], SDATA1};
                     bit_q <= bit_q + 5'd1;
                     if (bit_q == 5'd15) begin
                        state_q <= StQuiet;
                        cs_n_q  <= 1'b1;
                        sclk_q  <= 1'b1;
                        pot_q   <= {6'd0, sh0_q[10:0], SDATA0};
                        ref_q   <= {6'd0, sh1_q[10:0], SDATA1};
                        valid_q <= 1'b1;
                        quiet_q <= '0;
                     end
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            StQuiet: begin
               // Enable is ignored here, so a frame always ends with a full quiet period.
               if (quiet_q == QuietLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  quiet_q <= quiet_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               cs_n_q  <= 1'b1;
               sclk_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign CS_N  = cs_n_q;
   assign SCLK  = sclk_q;
   assign POT   = pot_q;
   assign REF   = ref_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: self-checking bench for adc_spi_capture. A small ADC
// model serves 16-bit words MSB first (new bit after each SCLK fall). Expected
// samples are the low 12 bits of the served word.
module tb_adc_spi_capture;

   localparam int unsigned ClkDiv   = 4;
   localparam int unsigned QuietCyc = 8;

   logic        clk;
   logic        rst;
   logic        Ena_ADC;
   logic        SDATA0;
   logic        SDATA1;
   logic        CS_N;
   logic        SCLK;
   logic [17:0] POT;
   logic [17:0] REF;
   logic        valid;
   logic        busy;

   logic [15:0] w0;
   logic [15:0] w1;
   int          fall_cnt;
   int          n_total;
   int          n_bad;

   adc_spi_capture #(
      .CLK_DIV   (ClkDiv),
      .QUIET_CYC (QuietCyc)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .Ena_ADC (Ena_ADC),
      .SDATA0  (SDATA0),
      .SDATA1  (SDATA1),
      .CS_N    (CS_N),
      .SCLK    (SCLK),
      .POT     (POT),
      .REF     (REF),
      .valid   (valid),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: a new bit is presented after each SCLK fall while selected.
   initial begin
      SDATA0   = 1'b0;
      SDATA1   = 1'b0;
      fall_cnt = 0;
      forever begin
         @(negedge SCLK or posedge CS_N);
         if (CS_N === 1'b1) begin
            fall_cnt = 0;
         end else if (fall_cnt < 16) begin
            SDATA0   = w0[4'(15 - fall_cnt)];
            SDATA1   = w1[4'(15 - fall_cnt)];
            fall_cnt = fall_cnt + 1;
         end
      end
   end

   function automatic logic [17:0] exp_sample(input logic [15:0] w);
      return 18'(w % 16'd4096);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Observe one frame from its first CS_N-low sample up to the sample where
   // CS_N returns high, then check timing and captured data.
   task automatic run_and_check(input string tag, input int drop_at);
      int   t;
      int   cyc;
      int   low;
      int   rises;
      int   last_rise;
      int   pmin;
      int   pmax;
      int   vlow;
      logic prev;
      t = 0; cyc = 0; low = 0; rises = 0; last_rise = 0;
      pmin = 100000; pmax = 0; vlow = 0; prev = 1'b1;
      while (CS_N !== 1'b0 && t < 400) begin
         step();
         t++;
      end
      check({tag, "_start"}, 32'(CS_N), 32'd0);
      t = 0;
      while (CS_N === 1'b0 && t < 2000) begin
         cyc++;
         low++;
         if (valid === 1'b1) vlow++;
         if (SCLK === 1'b1 && prev === 1'b0) begin
            rises++;
            if (rises > 1) begin
               if (cyc - last_rise < pmin) pmin = cyc - last_rise;
               if (cyc - last_rise > pmax) pmax = cyc - last_rise;
            end
            last_rise = cyc;
            if (rises == drop_at) Ena_ADC = 1'b0;
         end
         prev = SCLK;
         step();
         t++;
      end
      cyc++;
      if (SCLK === 1'b1 && prev === 1'b0) begin
         rises++;
         if (cyc - last_rise < pmin) pmin = cyc - last_rise;
         if (cyc - last_rise > pmax) pmax = cyc - last_rise;
      end
      check({tag, "_cs_low"}, 32'(low), 32'(32 * ClkDiv));
      check({tag, "_rises"}, 32'(rises), 32'd16);
      check({tag, "_pmin"}, 32'(pmin), 32'(2 * ClkDiv));
      check({tag, "_pmax"}, 32'(pmax), 32'(2 * ClkDiv));
      check({tag, "_early_valid"}, 32'(vlow), 32'd0);
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_sclk_end"}, 32'(SCLK), 32'd1);
      check({tag, "_pot"}, 32'(POT), 32'(exp_sample(w0)));
      check({tag, "_ref"}, 32'(REF), 32'(exp_sample(w1)));
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy !== 1'b0 && t < 100) begin
         step();
         t++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic pulse_frame(input string tag);
      Ena_ADC = 1'b1;
      step();
      Ena_ADC = 1'b0;
      run_and_check(tag, 0);
      step();
      check({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
      wait_idle(tag);
   endtask

   initial begin
      int   hi;
      int   blow;
      int   vextra;
      int   nv;
      int   t;
      int   rises;
      int   lows;
      logic prev;
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      Ena_ADC = 1'b0;
      w0      = '0;
      w1      = '0;

      // Reset values
      repeat (3) step();
      check("rst_cs_n", 32'(CS_N), 32'd1);
      check("rst_sclk", 32'(SCLK), 32'd1);
      check("rst_pot", 32'(POT), 32'd0);
      check("rst_ref", 32'(REF), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // Single frame with the reference pattern
      w0 = 16'h0ABC;
      w1 = 16'h0123;
      pulse_frame("single");

      // Full scale
      w0 = 16'h0FFF;
      w1 = 16'h0FFF;
      pulse_frame("fullscale");
      check("fs_pot_upper", 32'(POT[17:12]), 32'd0);
      check("fs_ref_upper", 32'(REF[17:12]), 32'd0);

      // Random words; the top nibble is junk that must be discarded
      for (int i = 0; i < 5; i++) begin
         w0 = 16'($urandom);
         w1 = 16'($urandom);
         pulse_frame("random");
         repeat ($urandom_range(0, 5)) step();
      end

      // Continuous enable: three back-to-back frames
      nv = 0;
      vextra = 0;
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      Ena_ADC = 1'b1;
      step();
      for (int f = 0; f < 3; f++) begin
         if (f == 2) Ena_ADC = 1'b0;
         run_and_check("cont", 0);
         if (valid === 1'b1) nv++;
         if (f < 2) begin
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            hi = 0;
            blow = 0;
            t = 0;
            while (CS_N === 1'b1 && t < 100) begin
               hi++;
               if (busy === 1'b0) blow++;
               if (hi > 1 && valid === 1'b1) vextra++;
               step();
               t++;
            end
            check("cont_gap_cs_high", 32'(hi), 32'(QuietCyc + 1));
            check("cont_gap_busy_low", 32'(blow), 32'd1);
         end
      end
      check("cont_valid_pulses", 32'(nv), 32'd3);
      check("cont_extra_valid", 32'(vextra), 32'd0);
      step();
      wait_idle("cont");
      lows = 0;
      repeat (60) begin
         step();
         if (CS_N === 1'b0) lows++;
      end
      check("cont_stops", 32'(lows), 32'd0);

      // Reset mid-frame after the 7th SCLK rise
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      Ena_ADC = 1'b1;
      step();
      Ena_ADC = 1'b0;
      rises = 0;
      prev = 1'b1;
      t = 0;
      while (rises < 7 && t < 2000) begin
         step();
         t++;
         if (SCLK === 1'b1 && prev === 1'b0) rises++;
         prev = SCLK;
      end
      check("mid_rises", 32'(rises), 32'd7);
      rst = 1'b1;
      step();
      check("mid_cs_n", 32'(CS_N), 32'd1);
      check("mid_sclk", 32'(SCLK), 32'd1);
      check("mid_pot", 32'(POT), 32'd0);
      check("mid_ref", 32'(REF), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      nv = 0;
      repeat (300) begin
         step();
         if (valid === 1'b1) nv++;
      end
      check("mid_no_valid", 32'(nv), 32'd0);
      check("mid_pot_hold", 32'(POT), 32'd0);
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      pulse_frame("after_mid");

      // Enable dropped at the 3rd SCLK rise
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      Ena_ADC = 1'b1;
      step();
      run_and_check("drop", 3);
      step();
      wait_idle("drop");
      lows = 0;
      blow = 0;
      repeat (50) begin
         step();
         if (CS_N === 1'b0) lows++;
         if (busy === 1'b1) blow++;
      end
      check("drop_stays_idle", 32'(lows), 32'd0);
      check("drop_busy_low", 32'(blow), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
